// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage: FSM state codes, the
// bubble instruction, the default reset PC and small PC/counter helpers.
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_ISSUE = 2'd0;  // next request ready to go out
  localparam fetch_state_t ST_WAIT  = 2'd1;  // request outstanding
  localparam fetch_state_t ST_HOLD  = 2'd2;  // response parked, decode stalled
  localparam fetch_state_t ST_DRAIN = 2'd3;  // stale response still to arrive

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_decode_reg.sv
// -----------------------------------------------------------------------------
// fetch_decode_reg
// IF/ID pipeline register. Priority: bubble > hold > load. A bubble replaces
// the instruction with NOP_INSTR and clears valid but keeps the PC fields.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   bubble, hold, load              update controls
//   next_instr/next_pc/next_pcplus4 values captured on load
//   instr, pc, pcplus4, valid       registered decode-stage outputs
// -----------------------------------------------------------------------------
module fetch_decode_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bubble,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] next_instr,
  input  logic [31:0] next_pc,
  input  logic [31:0] next_pcplus4,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        valid
);

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr   <= NOP_INSTR;
      pc      <= 32'd0;
      pcplus4 <= 32'd0;
      valid   <= 1'b0;
    end else if (bubble) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (hold) begin
      instr <= instr;
    end else if (load) begin
      instr   <= next_instr;
      pc      <= next_pc;
      pcplus4 <= next_pcplus4;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch with one outstanding I-cache request and the IF/ID
// register. Handles load-use stalls (FEN=0), execute-stage redirects
// (PCSrcE) and variable cache latency, inserting bubbles when idle.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   FEN                           0 = hold PC and decode register
//   PCSrcE, PCTargetE             redirect request and target (bits [1:0] ignored)
//   ic_req, ic_addr               combinational request to the I-cache
//   ic_rvalid, ic_rdata           I-cache response
//   InstrD, PCD, PCPlus4D, ValidD decode-stage outputs (registered)
//   perf_bubbles, perf_redirects  saturating counters, present only when
//                                 FETCH_PERF_EN is defined, else tied to 0
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        FEN,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_rvalid,
  input  logic [31:0] ic_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_redirects
);

  fetch_state_t state, state_next;
  logic [31:0]  pcf, pcf_next, pcf_plus4;
  logic [31:0]  hold_instr;
  logic         capture;
  logic         req_raw;
  logic         dec_bubble, dec_hold, dec_load;

  assign pcf_plus4 = pcf + 32'd4;  // wraps silently at the top of memory

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pcf_next   = pcf;
    req_raw    = 1'b0;
    ic_addr    = pcf;
    capture    = 1'b0;
    dec_bubble = 1'b0;
    dec_hold   = 1'b0;
    dec_load   = 1'b0;
    if (PCSrcE) begin
      // Redirect wins over everything: flush decode, retarget, and only
      // drain when a request is still in flight.
      pcf_next   = align_word(PCTargetE);
      dec_bubble = 1'b1;
      case (state)
        ST_WAIT, ST_DRAIN: state_next = ic_rvalid ? ST_ISSUE : ST_DRAIN;
        default:           state_next = ST_ISSUE;
      endcase
    end else begin
      case (state)
        ST_ISSUE: begin
          req_raw    = 1'b1;
          state_next = ST_WAIT;
          dec_bubble = FEN;
          dec_hold   = ~FEN;
        end
        ST_WAIT: begin
          if (ic_rvalid && FEN) begin
            // Hand the word to decode and chain the next request at once.
            dec_load = 1'b1;
            pcf_next = pcf_plus4;
            req_raw  = 1'b1;
            ic_addr  = pcf_plus4;
          end else if (ic_rvalid) begin
            capture    = 1'b1;
            dec_hold   = 1'b1;
            state_next = ST_HOLD;
          end else begin
            dec_bubble = FEN;
            dec_hold   = ~FEN;
          end
        end
        ST_HOLD: begin
          if (FEN) begin
            dec_load   = 1'b1;
            pcf_next   = pcf_plus4;
            req_raw    = 1'b1;
            ic_addr    = pcf_plus4;
            state_next = ST_WAIT;
          end else begin
            dec_hold = 1'b1;
          end
        end
        default: begin  // ST_DRAIN: discard the stale response
          dec_bubble = FEN;
          dec_hold   = ~FEN;
          if (ic_rvalid) state_next = ST_ISSUE;
        end
      endcase
    end
  end

  // Keeps the request low while reset is asserted.
  assign ic_req = req_raw & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ISSUE;
      pcf   <= align_word(RESET_PC);
    end else begin
      state <= state_next;
      pcf   <= pcf_next;
    end
  end

  // NOTE: the parked word needs no reset; it is only read in HOLD, which is
  // reachable solely through a cycle that writes it.
  always_ff @(posedge clk) begin
    if (capture) hold_instr <= ic_rdata;
  end

  fetch_decode_reg u_decode_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .bubble       (dec_bubble),
    .hold         (dec_hold),
    .load         (dec_load),
    .next_instr   ((state == ST_HOLD) ? hold_instr : ic_rdata),
    .next_pc      (pcf),
    .next_pcplus4 (pcf_plus4),
    .instr        (InstrD),
    .pc           (PCD),
    .pcplus4      (PCPlus4D),
    .valid        (ValidD)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] bubbles_q, redirects_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubbles_q   <= 32'd0;
      redirects_q <= 32'd0;
    end else begin
      if (dec_bubble) bubbles_q   <= sat_inc(bubbles_q);
      if (PCSrcE)     redirects_q <= sat_inc(redirects_q);
    end
  end

  assign perf_bubbles   = bubbles_q;
  assign perf_redirects = redirects_q;
`else
  assign perf_bubbles   = 32'd0;
  assign perf_redirects = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        FEN = 1'b1, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'd0;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_rvalid = 1'b0;
  logic [31:0] ic_rdata = 32'd0;
  logic [31:0] InstrD, PCD, PCPlus4D, perf_bubbles, perf_redirects;
  logic        ValidD;

  int tests_run = 0, tests_failed = 0;

  typedef struct {
    logic fen; logic pcsrc; logic [31:0] tgt;
    logic req; logic [31:0] addr; logic valid; logic [31:0] pcd;
  } step_t;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .FEN(FEN), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .perf_bubbles(perf_bubbles), .perf_redirects(perf_redirects)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00A0_0093;
  endfunction

  // Directed latencies: two slow addresses, everything else a 1-cycle hit.
  function automatic int lat_of(input logic [31:0] a);
    return (a == 32'h8 || a == 32'h14) ? 3 : 1;
  endfunction

  // ---------------- instruction cache model ----------------
  logic        s_req;
  logic [31:0] s_addr, paddr;
  bit          pending, rand_lat;
  int          cnt, proto_errs;

  always @(negedge clk) begin
    s_req  = ic_req;
    s_addr = ic_addr;
  end

  always @(posedge clk) begin
    #1;
    ic_rvalid = 1'b0;
    if (!rst_n) pending = 1'b0;
    else begin
      if (s_req) begin
        if (pending) proto_errs++;
        pending = 1'b1;
        paddr   = s_addr;
        cnt     = rand_lat ? int'($urandom_range(1, 4)) : lat_of(s_addr);
      end
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          ic_rvalid = 1'b1;
          ic_rdata  = mem_word(paddr);
          pending   = 1'b0;
        end
      end
    end
  end

  // ---------------- performance counter model ----------------
  // A bubble is loaded on every redirect edge, and on every enabled edge
  // after which decode does not hold a real instruction.
  int exp_bubbles, exp_redirects;
  logic m_fen, m_pcsrc;

  always @(posedge clk) begin
    if (rst_n) begin
      m_fen   = FEN;
      m_pcsrc = PCSrcE;
      #2;
      if (m_pcsrc) exp_redirects++;
      if (m_pcsrc || (m_fen && !ValidD)) exp_bubbles++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic fen, input logic pcsrc, input logic [31:0] tgt);
    FEN = fen; PCSrcE = pcsrc; PCTargetE = tgt;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    FEN = 1'b1; PCSrcE = 1'b0; PCTargetE = 32'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (ic_req !== 1'b0 || InstrD !== NOP || PCD !== 32'd0 || PCPlus4D !== 32'd0 ||
        ValidD !== 1'b0 || perf_bubbles !== 32'd0 || perf_redirects !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset: req=%b instr=%h pcd=%h pc4=%h valid=%b perf=%0d/%0d, want 0 %h 0 0 0 0/0",
               ic_req, InstrD, PCD, PCPlus4D, ValidD, perf_bubbles, perf_redirects, NOP);
    end
    @(posedge clk);
    #2;
    exp_bubbles = 0; exp_redirects = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_stream_miss();
    step_t tab[6];
    logic [31:0] ei;
    tab = '{'{1, 0, 0, 1, 32'h0, 0, 32'h0}, '{1, 0, 0, 1, 32'h4, 0, 32'h0},
            '{1, 0, 0, 1, 32'h8, 1, 32'h0}, '{1, 0, 0, 0, 32'h0, 1, 32'h4},
            '{1, 0, 0, 0, 32'h0, 0, 32'h4}, '{1, 0, 0, 1, 32'hC, 0, 32'h4}};
    foreach (tab[i]) begin
      drive(tab[i].fen, tab[i].pcsrc, tab[i].tgt);
      tests_run++;
      if (ic_req !== tab[i].req || (tab[i].req && ic_addr !== tab[i].addr)) begin
        tests_failed++;
        $display("FAIL stream c%0d req/addr: got %b/%h want %b/%h", i + 1, ic_req, ic_addr, tab[i].req, tab[i].addr);
      end
      ei = tab[i].valid ? mem_word(tab[i].pcd) : NOP;
      tests_run++;
      if (ValidD !== tab[i].valid || PCD !== tab[i].pcd || InstrD !== ei ||
          (tab[i].valid && PCPlus4D !== tab[i].pcd + 32'd4)) begin
        tests_failed++;
        $display("FAIL stream c%0d decode: got v=%b pc=%h i=%h want v=%b pc=%h i=%h", i + 1, ValidD, PCD, InstrD, tab[i].valid, tab[i].pcd, ei);
      end
      advance();
    end
  endtask

  task automatic test_hold();
    step_t tab[4];
    logic [31:0] ei;
    tab = '{'{0, 0, 0, 0, 32'h0, 1, 32'h8}, '{0, 0, 0, 0, 32'h0, 1, 32'h8},
            '{1, 0, 0, 1, 32'h10, 1, 32'h8}, '{1, 0, 0, 1, 32'h14, 1, 32'hC}};
    foreach (tab[i]) begin
      drive(tab[i].fen, tab[i].pcsrc, tab[i].tgt);
      tests_run++;
      if (ic_req !== tab[i].req || (tab[i].req && ic_addr !== tab[i].addr)) begin
        tests_failed++;
        $display("FAIL hold s%0d req/addr: got %b/%h want %b/%h", i, ic_req, ic_addr, tab[i].req, tab[i].addr);
      end
      ei = tab[i].valid ? mem_word(tab[i].pcd) : NOP;
      tests_run++;
      if (ValidD !== tab[i].valid || PCD !== tab[i].pcd || InstrD !== ei) begin
        tests_failed++;
        $display("FAIL hold s%0d decode: got v=%b pc=%h i=%h want v=%b pc=%h i=%h", i, ValidD, PCD, InstrD, tab[i].valid, tab[i].pcd, ei);
      end
      advance();
    end
  endtask

  // Redirect with a miss outstanding (drain), then redirect during a stall.
  task automatic test_redirect();
    step_t tab[9];
    logic [31:0] ei;
    tab = '{'{1, 1, 32'h203, 0, 32'h0, 1, 32'h10}, '{1, 0, 0, 0, 32'h0, 0, 32'h10},
            '{1, 0, 0, 0, 32'h0, 0, 32'h10},       '{1, 0, 0, 1, 32'h200, 0, 32'h10},
            '{1, 0, 0, 1, 32'h204, 0, 32'h10},     '{0, 1, 32'h401, 0, 32'h0, 1, 32'h200},
            '{1, 0, 0, 1, 32'h400, 0, 32'h200},    '{1, 0, 0, 1, 32'h404, 0, 32'h200},
            '{1, 0, 0, 1, 32'h408, 1, 32'h400}};
    foreach (tab[i]) begin
      drive(tab[i].fen, tab[i].pcsrc, tab[i].tgt);
      tests_run++;
      if (ic_req !== tab[i].req || (tab[i].req && ic_addr !== tab[i].addr)) begin
        tests_failed++;
        $display("FAIL redirect s%0d req/addr: got %b/%h want %b/%h", i, ic_req, ic_addr, tab[i].req, tab[i].addr);
      end
      ei = tab[i].valid ? mem_word(tab[i].pcd) : NOP;
      tests_run++;
      if (ValidD !== tab[i].valid || PCD !== tab[i].pcd || InstrD !== ei) begin
        tests_failed++;
        $display("FAIL redirect s%0d decode: got v=%b pc=%h i=%h want v=%b pc=%h i=%h", i, ValidD, PCD, InstrD, tab[i].valid, tab[i].pcd, ei);
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    int n_req = 0;
    bit got = 0;
    drive(1'b1, 1'b1, 32'hFFFF_FFFE);
    tests_run++;
    if (ic_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap redirect-cycle req: got %b want 0", ic_req);
    end
    advance();
    for (int i = 0; i < 20 && !got; i++) begin
      drive(1'b1, 1'b0, 32'd0);
      if (ic_req) begin
        tests_run++;
        if (n_req < 2 && ic_addr !== (n_req == 0 ? 32'hFFFF_FFFC : 32'h0)) begin
          tests_failed++;
          $display("FAIL wrap req%0d addr: got %h want %h", n_req, ic_addr, n_req == 0 ? 32'hFFFF_FFFC : 32'h0);
        end
        n_req++;
      end
      if (ValidD) begin
        got = 1;
        tests_run++;
        if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || InstrD !== mem_word(32'hFFFF_FFFC) || n_req < 2) begin
          tests_failed++;
          $display("FAIL wrap decode: got pc=%h pc4=%h i=%h reqs=%0d want fffffffc 00000000 %h >=2",
                   PCD, PCPlus4D, InstrD, n_req, mem_word(32'hFFFF_FFFC));
        end
      end
      advance();
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL wrap timeout: got no valid instruction want one within 20 cycles");
    end
  endtask

  // Random stalls, redirects and latencies against a program-order model:
  // each instruction consumed by decode must be the next PC in sequence.
  task automatic test_random();
    logic [31:0] exp_pc, tgt, p_instr, p_pc;
    logic        fen, pcsrc, p_valid;
    int          consumed = 0;
    rand_lat = 1'b1;
    tgt = $urandom;
    drive(1'b1, 1'b1, tgt);
    exp_pc = {tgt[31:2], 2'b00};
    advance();
    for (int cyc = 0; cyc < 660; cyc++) begin
      if (cyc < 600) begin
        fen   = ($urandom_range(0, 3) != 0);
        pcsrc = ($urandom_range(0, 11) == 0);
        tgt   = $urandom;
      end else begin
        fen = 1'b1; pcsrc = 1'b0; tgt = 32'd0;
      end
      drive(fen, pcsrc, tgt);
      p_instr = InstrD; p_pc = PCD; p_valid = ValidD;
      if (ic_req) begin
        tests_run++;
        if (ic_addr[1:0] !== 2'b00 || pcsrc) begin
          tests_failed++;
          $display("FAIL rand req: addr=%h pcsrc=%b want aligned and no redirect", ic_addr, pcsrc);
        end
      end
      if (ValidD && fen) begin
        tests_run++;
        if (PCD !== exp_pc || InstrD !== mem_word(exp_pc) || PCPlus4D !== exp_pc + 32'd4) begin
          tests_failed++;
          $display("FAIL rand order: got pc=%h i=%h pc4=%h want pc=%h i=%h", PCD, InstrD, PCPlus4D, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
        if (cyc >= 600) consumed++;
      end
      if (pcsrc) exp_pc = {tgt[31:2], 2'b00};
      advance();
      if (pcsrc) begin
        tests_run++;
        if (ValidD !== 1'b0 || InstrD !== NOP) begin
          tests_failed++;
          $display("FAIL rand flush: got v=%b i=%h want 0 %h", ValidD, InstrD, NOP);
        end
      end else if (!fen) begin
        tests_run++;
        if (ValidD !== p_valid || InstrD !== p_instr || PCD !== p_pc) begin
          tests_failed++;
          $display("FAIL rand stall: got v=%b i=%h pc=%h want %b %h %h", ValidD, InstrD, PCD, p_valid, p_instr, p_pc);
        end
      end
      if (!ValidD) begin
        tests_run++;
        if (InstrD !== NOP || PCD !== p_pc) begin
          tests_failed++;
          $display("FAIL rand bubble: got i=%h pc=%h want %h %h", InstrD, PCD, NOP, p_pc);
        end
      end
    end
    tests_run++;
    if (consumed < 8 || proto_errs != 0) begin
      tests_failed++;
      $display("FAIL rand progress: got %0d instrs, %0d overlaps want >=8 and 0", consumed, proto_errs);
    end
    rand_lat = 1'b0;
  endtask

  task automatic test_perf(input string tag);
    logic [31:0] eb, er;
`ifdef FETCH_PERF_EN
    eb = exp_bubbles; er = exp_redirects;
`else
    eb = 32'd0; er = 32'd0;
`endif
    @(negedge clk);
    tests_run++;
    if (perf_bubbles !== eb || perf_redirects !== er) begin
      tests_failed++;
      $display("FAIL perf %s: got bubbles=%0d redirects=%0d want %0d %0d", tag, perf_bubbles, perf_redirects, eb, er);
    end
    advance();
  endtask

  initial begin
    rand_lat = 1'b0;
    proto_errs = 0;
    test_reset();
    test_stream_miss();
    test_hold();
    test_redirect();
    test_perf("directed");
    test_wrap();
    test_random();
    test_perf("random");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within 100000 ns");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage plus IF/ID pipeline register for the cached RV32I pipeline. Issues one-outstanding requests to the instruction cache, absorbs variable cache latency, and presents instructions to decode. Obeys the load-use stall enable (FEN) from the hazard logic and redirects on a taken branch/jump resolved in execute. Inserts bubbles when no instruction is available.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- FEN  in  1  fetch/decode enable; 0 = hold PCF and the decode register (load-use stall)
- PCSrcE  in  1  taken branch/jump in execute
- PCTargetE  in  32  redirect target; bits [1:0] ignored
- ic_req  out  1  request pulse to instruction cache
- ic_addr  out  32  request address, [1:0] always 00
- ic_rvalid  in  1  response valid (≥1 cycle after ic_req; one outstanding max)
- ic_rdata  in  32  instruction word
- InstrD  out  32  instruction to decode
- PCD, PCPlus4D  out  32 each  PC of InstrD and PC+4
- ValidD  out  1  InstrD is a real instruction (0 = bubble)
- perf_bubbles, perf_redirects  out  32 each  performance counters (see Configuration)

## Operation
- State machine: ISSUE, WAIT, HOLD, DRAIN. PCF = address of the in-flight/held instruction (or next to issue in ISSUE/DRAIN).
- ISSUE: ic_req=1, ic_addr=PCF → WAIT. If PCSrcE this cycle: no request, PCF←target, stay ISSUE.
- WAIT, ic_rvalid, FEN, ~PCSrcE: decode reg ← {ic_rdata, PCF, PCF+4}, ValidD=1; PCF←PCF+4; ic_req=1, ic_addr=PCF+4 same cycle; stay WAIT.
- WAIT, ic_rvalid, ~FEN: word+PC captured in hold buffer → HOLD; decode reg held; no request.
- WAIT, ~ic_rvalid: FEN=1 → decode reg loads bubble; FEN=0 → held.
- HOLD, FEN: decode reg ← buffer, PCF←PCF+4, request issued for new PCF → WAIT. HOLD, ~FEN: stay.
- DRAIN: wait for ic_rvalid, discard data → ISSUE. Decode reg gets bubble while FEN=1.
- PCSrcE (any state, highest priority after reset): PCF←{PCTargetE[31:2],2'b00}; decode reg ← bubble regardless of FEN; buffer dropped. Next state: WAIT without rvalid → DRAIN; WAIT with rvalid (data dropped), HOLD, ISSUE → ISSUE; DRAIN with rvalid → ISSUE, else DRAIN.
- Bubble = InstrD 32'h0000_0013 (addi x0,x0,0), ValidD=0, PCD/PCPlus4D unchanged.
- PC arithmetic 32-bit, wraps 32'hFFFF_FFFC → 32'h0000_0000 silently.

## Timing
- Reset (async assert, sync deassert assumed): state ISSUE, PCF=RESET_PC, ic_req=0, InstrD=32'h0000_0013, PCD=0, PCPlus4D=0, ValidD=0, counters 0.
- First ic_req in the first clk edge-cycle after rst_n deasserts.
- 1-cycle cache hit: sustained one instruction/cycle; instruction visible in InstrD the cycle after ic_rvalid.
- Redirect penalty with 1-cycle hits: target request issued the cycle after PCSrcE; ≥2 bubbles.
- ic_req is combinational from state/inputs; all other outputs registered.
- ic_rvalid in ISSUE or HOLD is a protocol error; ignored.

## Configuration
- FETCH_PERF_EN defined: perf_bubbles increments each cycle the decode reg loads a bubble; perf_redirects increments on each PCSrcE cycle; both saturate at 32'hFFFF_FFFF.
- Undefined: counter logic removed, both ports tied to 0.

## Structure
- fetch_pkg: state enum (ISSUE, WAIT, HOLD, DRAIN), NOP_INSTR = 32'h0000_0013, default RESET_PC.
- Sub-module fetch_decode_reg: IF/ID register with load / hold / bubble controls, 3-way priority (bubble > hold > load).

## Test plan
- Reset, RESET_PC=0, 1-cycle hits returning 32'h00A00093… → ic_addr 0,4,8,… one per cycle; ValidD=1 from cycle 3; PCD tracks 0,4,8.
- 3-cycle miss on addr 8 → two bubbles (ValidD=0, InstrD=0x13), then PCD=8, no second request while outstanding.
- FEN=0 for 2 cycles coinciding with ic_rvalid for addr 0xC → HOLD; InstrD/PCD frozen; on FEN=1 PCD=0xC, next ic_addr=0x10.
- PCSrcE, PCTargetE=0x203 while request for 0x14 outstanding → DRAIN; stale 0x14 data discarded; next ic_addr=0x200, first valid PCD=0x200.
- PCSrcE and FEN=0 same cycle → decode reg bubbles, PCF=target.
- With FETCH_PERF_EN: two redirects plus 5 bubble cycles → perf_redirects=2, perf_bubbles=5; without: both 0.
